mul_sequencer: RTL and testbench

Iterative multiply sequencer for the Exec stage. It accepts a multiply (MUL) or multiply-accumulate (MLA) issued in Exec and computes the 32-bit low product with a radix-2 shift-add datapath. While the operation runs it holds the pipeline in Exec with a stall signal, and it delivers the result and N/Z flags in the cycle the pipeline is released. The hazard unit ORs `StallMul` into StallF/StallD/StallE. Exec muxes `MulResultE` into ALUResultE when `DoneE` is high.

---
 rtl/mul_sequencer_if.sv | 27 ++
 rtl/mul_sequencer.sv | 94 +++++++++
 tb/tb_mul_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// Exec-stage multiply handshake bundle: issue/operands from the pipeline,
// stall/done/result back from the sequencer.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             StartE;
  logic             AccumE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic [WIDTH-1:0] SrcCE;
  logic             KillE;
  logic             StallMul;
  logic             BusyE;
  logic             DoneE;
  logic [WIDTH-1:0] MulResultE;
  logic [1:0]       MulFlagsE;

  modport master (
    output StartE, AccumE, SrcAE, SrcBE, SrcCE, KillE,
    input  StallMul, BusyE, DoneE, MulResultE, MulFlagsE
  );

  modport slave (
    input  StartE, AccumE, SrcAE, SrcBE, SrcCE, KillE,
    output StallMul, BusyE, DoneE, MulResultE, MulFlagsE
  );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add MUL/MLA sequencer that stalls Exec until the low product is ready.
// Optional MUL_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are zero.
module mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic           clk,
  input  logic           reset,
  mul_sequencer_if.slave mif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0] mp_q, mp_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             start_ok;
  logic             last_iter;
  logic [WIDTH-1:0] mp_shift;

  assign start_ok = mif.StartE && !mif.KillE;
  assign mp_shift = mp_q >> 1;

`ifdef MUL_EARLY_TERM_EN
  // Nothing left to add once the shifted multiplier is empty.
  assign last_iter = (cnt_q == CNTW'(WIDTH-1)) || (mp_shift == '0);
`else
  assign last_iter = (cnt_q == CNTW'(WIDTH-1));
`endif

  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        mc_d  = mif.SrcAE;
        mp_d  = mif.SrcBE;
        acc_d = mif.AccumE ? mif.SrcCE : '0;
        cnt_d = '0;
        if (start_ok) state_d = S_RUN;
      end
      S_RUN: begin
        if (mp_q[0]) acc_d = acc_q + mc_q;
        mc_d  = mc_q << 1;
        mp_d  = mp_shift;
        cnt_d = cnt_q + CNTW'(1);
        if (mif.KillE)    state_d = S_IDLE;
        else if (last_iter) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mc_q    <= '0;
      mp_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result/flags are gated to DONE so Exec can OR-mux them without extra qualification.
  always_comb begin
    mif.StallMul   = ((state_q == S_IDLE) && start_ok) || (state_q == S_RUN);
    mif.BusyE      = (state_q != S_IDLE);
    mif.DoneE      = (state_q == S_DONE);
    mif.MulResultE = '0;
    mif.MulFlagsE  = 2'b00;
    if (state_q == S_DONE) begin
      mif.MulResultE = acc_q;
      mif.MulFlagsE  = {acc_q[WIDTH-1], (acc_q == '0)};
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized + directed bench for mul_sequencer against an arithmetic reference model.
module tb_mul_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mul_sequencer_if #(.WIDTH(W)) mif ();
  mul_sequencer #(.WIDTH(W), .CNTW(5)) dut (.clk(clk), .reset(reset), .mif(mif));

  function automatic logic [31:0] ref_res(input logic [31:0] a, b, c, input bit acc);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b} + (acc ? {32'd0, c} : 64'd0);
    return p[31:0];
  endfunction

  // Cycle index (from the StartE cycle) at which DoneE is expected.
  function automatic int exp_done(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
    int n;
    n = 0;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return ((n < 1) ? 1 : n) + 1;
`else
    return W + 1;
`endif
  endfunction

  task automatic do_op(input logic [31:0] a, b, c, input bit acc, input bit hold, input int kd,
                       output int done_cyc, output logic [31:0] res, output logic [1:0] flg,
                       output bit ok);
    @(negedge clk);
    mif.StartE = 1'b1; mif.KillE = 1'b0; mif.AccumE = acc;
    mif.SrcAE = a; mif.SrcBE = b; mif.SrcCE = c;
    #1;
    ok = (mif.StallMul === 1'b1) && (mif.BusyE === 1'b0) && (mif.DoneE === 1'b0);
    done_cyc = -1; res = 'x; flg = 'x;
    for (int cy = 1; cy < 120; cy++) begin
      @(negedge clk);
      if (!hold) mif.StartE = 1'b0;
      mif.KillE = (cy == kd);
      mif.SrcAE = $urandom; mif.SrcBE = $urandom; mif.SrcCE = $urandom; mif.AccumE = $urandom;
      #1;
      if (mif.DoneE === 1'b1) begin
        done_cyc = cy; res = mif.MulResultE; flg = mif.MulFlagsE;
        if (mif.StallMul !== 1'b0) ok = 0;
        break;
      end
      if (mif.StallMul !== 1'b1 || mif.BusyE !== 1'b1 || mif.MulResultE !== 32'd0) ok = 0;
    end
    if (!hold) mif.StartE = 1'b0;
  endtask

  task automatic chk_op(input string nm, input logic [31:0] a, b, c, input bit acc,
                        input int d, input logic [31:0] r, input logic [1:0] f, input bit ok);
    logic [31:0] er;
    er = ref_res(a, b, c, acc);
    total += 4;
    if (d !== exp_done(b)) begin bad++; $display("FAIL %s latency: got %0d want %0d", nm, d, exp_done(b)); end
    if (r !== er) begin bad++; $display("FAIL %s result: got %h want %h", nm, r, er); end
    if (f !== {er[31], er == 32'd0}) begin bad++; $display("FAIL %s flags: got %b want %b", nm, f, {er[31], er == 32'd0}); end
    if (ok !== 1'b1) begin bad++; $display("FAIL %s stall/busy: got %0d want 1", nm, ok); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mif.StartE = 0; mif.KillE = 0; mif.AccumE = 0; mif.SrcAE = 0; mif.SrcBE = 0; mif.SrcCE = 0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({mif.StallMul, mif.BusyE, mif.DoneE, mif.MulFlagsE, mif.MulResultE} !== 37'd0) begin
      bad++; $display("FAIL reset outputs: got %h want 0", {mif.StallMul, mif.BusyE, mif.DoneE, mif.MulFlagsE, mif.MulResultE});
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta [5] = '{32'd3, 32'd7, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    logic [31:0] tb [5] = '{32'd5, 32'd6, 32'hFFFFFFFF, 32'd1,        32'd0};
    logic [31:0] tc [5] = '{32'd0, 32'd100, 32'd0,     32'd0,         32'd0};
    bit          tacc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int d; logic [31:0] r; logic [1:0] f; bit ok;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], tc[i], tacc[i], 1'b0, -1, d, r, f, ok);
      chk_op($sformatf("directed%0d", i), ta[i], tb[i], tc[i], tacc[i], d, r, f, ok);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, c; bit acc;
    int d; logic [31:0] r; logic [1:0] f; bit ok;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom >> $urandom_range(0, 31); c = $urandom; acc = $urandom;
      do_op(a, b, c, acc, 1'b0, -1, d, r, f, ok);
      chk_op($sformatf("random%0d", i), a, b, c, acc, d, r, f, ok);
    end
  endtask

  task automatic test_kill();
    bit seen_done;
    int d; logic [31:0] r; logic [1:0] f; bit ok;
    seen_done = 0;
    @(negedge clk);
    mif.StartE = 1; mif.KillE = 0; mif.AccumE = 0; mif.SrcAE = 32'd123; mif.SrcBE = 32'hFFFFFFFF;
    for (int cy = 1; cy <= 11; cy++) begin
      @(negedge clk);
      mif.StartE = 0; mif.KillE = (cy == 10);
      #1;
      if (mif.DoneE === 1'b1) seen_done = 1;
      if (cy == 10) begin
        total++;
        if (mif.StallMul !== 1'b1) begin bad++; $display("FAIL kill stall_run: got %b want 1", mif.StallMul); end
      end
      if (cy == 11) begin
        total += 3;
        if (mif.BusyE !== 1'b0) begin bad++; $display("FAIL kill busy: got %b want 0", mif.BusyE); end
        if (mif.StallMul !== 1'b0) begin bad++; $display("FAIL kill stall: got %b want 0", mif.StallMul); end
        if (seen_done !== 1'b0) begin bad++; $display("FAIL kill done: got %b want 0", seen_done); end
      end
    end
    mif.KillE = 0;
    do_op(32'd2, 32'd2, 32'd0, 1'b0, 1'b0, -1, d, r, f, ok);
    chk_op("after_kill", 32'd2, 32'd2, 32'd0, 1'b0, d, r, f, ok);
  endtask

  task automatic test_kill_in_done();
    int d; logic [31:0] r; logic [1:0] f; bit ok;
    do_op(32'd5, 32'd3, 32'd0, 1'b0, 1'b0, exp_done(32'd3), d, r, f, ok);
    chk_op("kill_in_done", 32'd5, 32'd3, 32'd0, 1'b0, d, r, f, ok);
  endtask

  task automatic test_reset_mid();
    int d; logic [31:0] r; logic [1:0] f; bit ok;
    @(negedge clk);
    mif.StartE = 1; mif.KillE = 0; mif.AccumE = 1; mif.SrcAE = 32'hDEADBEEF; mif.SrcBE = 32'hFFFFFFFF;
    mif.SrcCE = 32'h1234;
    for (int cy = 1; cy <= 21; cy++) begin
      @(negedge clk);
      mif.StartE = 0; reset = (cy == 20);
      #1;
      if (cy == 21) begin
        total++;
        if ({mif.StallMul, mif.BusyE, mif.DoneE, mif.MulFlagsE, mif.MulResultE} !== 37'd0) begin
          bad++; $display("FAIL reset_mid outputs: got %h want 0", {mif.StallMul, mif.BusyE, mif.DoneE, mif.MulFlagsE, mif.MulResultE});
        end
      end
    end
    reset = 0;
    do_op(32'd9, 32'd9, 32'd0, 1'b0, 1'b0, -1, d, r, f, ok);
    chk_op("after_reset", 32'd9, 32'd9, 32'd0, 1'b0, d, r, f, ok);
  endtask

  task automatic test_start_kill_idle();
    @(negedge clk);
    mif.StartE = 1; mif.KillE = 1; mif.SrcBE = 32'd7;
    #1;
    total++;
    if (mif.StallMul !== 1'b0) begin bad++; $display("FAIL start_kill stall: got %b want 0", mif.StallMul); end
    @(negedge clk);
    mif.StartE = 0; mif.KillE = 0;
    #1;
    total++;
    if (mif.BusyE !== 1'b0) begin bad++; $display("FAIL start_kill busy: got %b want 0", mif.BusyE); end
  endtask

  task automatic test_back_to_back();
    int d1, d2; logic [31:0] r1, r2; logic [1:0] f1, f2; bit ok1, ok2;
    do_op(32'd2, 32'd3, 32'd0, 1'b0, 1'b1, -1, d1, r1, f1, ok1);
    do_op(32'd4, 32'd5, 32'd0, 1'b0, 1'b0, -1, d2, r2, f2, ok2);
    chk_op("b2b_first", 32'd2, 32'd3, 32'd0, 1'b0, d1, r1, f1, ok1);
    chk_op("b2b_second", 32'd4, 32'd5, 32'd0, 1'b0, d2, r2, f2, ok2);
    total++;
    if (d1 + 1 + d2 !== exp_done(32'd3) + 1 + exp_done(32'd5)) begin
      bad++; $display("FAIL b2b second_done_abs: got %0d want %0d", d1 + 1 + d2, exp_done(32'd3) + 1 + exp_done(32'd5));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_kill_idle();
    test_kill();
    test_kill_in_done();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
